// File: rtl/vector_lane_alu.sv
// Per-lane element ALU for the vector unit.
// One-cycle integer ops through an output register; MUL via iterative shift-add.
module vector_lane_alu #(
  parameter int LEN              = 32,
  parameter int ENTRY_INDEX_SIZE = 3,
  parameter int SHAMT_WIDTH      = $clog2(LEN)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [3:0]                  opcode,
  input  logic [LEN-1:0]              vs1,
  input  logic [LEN-1:0]              vs2,
  input  logic [LEN-1:0]              vd_old,
  input  logic                        mask_en,
  input  logic                        mask_bit,
  input  logic [ENTRY_INDEX_SIZE-1:0] idx_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LEN-1:0]              result,
  output logic                        out_we,
  output logic [ENTRY_INDEX_SIZE-1:0] out_idx,
  output logic                        illegal
);

  localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LEN - 1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_MIN  = 4'd8;
  localparam logic [3:0] OP_MAX  = 4'd9;
  localparam logic [3:0] OP_MINU = 4'd10;
  localparam logic [3:0] OP_MAXU = 4'd11;
  localparam logic [3:0] OP_MUL  = 4'd12;
  localparam logic [3:0] OP_SEQ  = 4'd13;
  localparam logic [3:0] OP_SLT  = 4'd14;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    OUT
  } state_t;

  state_t                        state_q;
  logic [LEN-1:0]                res_q;
  logic                          we_q;
  logic                          ill_q;
  logic [ENTRY_INDEX_SIZE-1:0]   idx_q;
  logic [LEN-1:0]                acc_q;
  logic [LEN-1:0]                mcand_q;
  logic [LEN-1:0]                mplier_q;
  logic [CW-1:0]                 cnt_q;

  logic                          accept;
  logic                          masked;
  logic [SHAMT_WIDTH-1:0]        shamt;
  logic                          lt_s;
  logic                          lt_u;
  logic [LEN-1:0]                alu_res;
  logic                          alu_ill;
  logic [LEN-1:0]                acc_d;

  assign in_ready  = (state_q == IDLE)
                   | ((state_q == OUT) & out_ready);
  assign out_valid = (state_q == OUT);
  assign result    = res_q;
  assign out_we    = we_q;
  assign out_idx   = idx_q;
  assign illegal   = ill_q;

  assign accept = in_valid & in_ready;
  assign masked = mask_en & ~mask_bit;
  assign shamt  = vs1[SHAMT_WIDTH-1:0];
  assign lt_s   = $signed(vs2) < $signed(vs1);
  assign lt_u   = vs2 < vs1;

  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (opcode)
      OP_ADD:  alu_res = vs2 + vs1;
      OP_SUB:  alu_res = vs2 - vs1;
      OP_AND:  alu_res = vs2 & vs1;
      OP_OR:   alu_res = vs2 | vs1;
      OP_XOR:  alu_res = vs2 ^ vs1;
      OP_SLL:  alu_res = vs2 << shamt;
      OP_SRL:  alu_res = vs2 >> shamt;
      OP_SRA:  alu_res = LEN'($signed(vs2) >>> shamt);
      OP_MIN:  alu_res = lt_s ? vs2 : vs1;
      OP_MAX:  alu_res = lt_s ? vs1 : vs2;
      OP_MINU: alu_res = lt_u ? vs2 : vs1;
      OP_MAXU: alu_res = lt_u ? vs1 : vs2;
      OP_MUL:  alu_res = '0;
      OP_SEQ:  alu_res = {{(LEN-1){1'b0}}, vs2 == vs1};
      OP_SLT:  alu_res = {{(LEN-1){1'b0}}, lt_s};
      default: alu_ill = 1'b1;
    endcase
  end

  // One multiplier bit per cycle; only the low LEN bits are kept,
  // which is the same for signed and unsigned operands.
  assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      res_q    <= '0;
      we_q     <= 1'b0;
      ill_q    <= 1'b0;
      idx_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else if (accept) begin
      idx_q <= idx_in;
      if (masked) begin
        res_q   <= vd_old;
        we_q    <= 1'b0;
        ill_q   <= 1'b0;
        state_q <= OUT;
      end else if (opcode == OP_MUL) begin
        acc_q    <= '0;
        mcand_q  <= vs2;
        mplier_q <= vs1;
        cnt_q    <= '0;
        state_q  <= MUL;
      end else begin
        res_q   <= alu_res;
        we_q    <= ~alu_ill;
        ill_q   <= alu_ill;
        state_q <= OUT;
      end
    end else begin
      case (state_q)
        MUL: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            res_q   <= acc_d;
            we_q    <= 1'b1;
            ill_q   <= 1'b0;
            state_q <= OUT;
          end
        end
        OUT: begin
          if (out_ready) state_q <= IDLE;
        end
        default: ;
      endcase
    end
  end

endmodule
